line_copy_engine: RTL
=====================

# line_copy_engine

Parametrised host-memory copy engine for the generic-processing AFU. It reads `num_lines` consecutive cache lines starting at a source line address and buffers them in an internal credit-managed FIFO. It then writes them, in order, to consecutive lines starting at a destination line address. It sits between the CSR decode and the MPF channel-0/channel-1 ports, replacing the fixed single-write datapath; a processing stage may later be inserted between FIFO head and write port.

## Interface
Parameters:
- `ADDR_W`, 42: line-address width.
- `DATA_W`, 512: line data width.
- `LEN_W`, 32: width of line count and status counters.
- `DEPTH`, 16: FIFO depth in lines; also the maximum number of reads in flight. Power of two, ≥2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: one-cycle request to begin a copy.
- `src_addr` in ADDR_W: first source line; sampled on accepted `start`.
- `dst_addr` in ADDR_W: first destination line; sampled on accepted `start`.
- `num_lines` in LEN_W: lines to copy; sampled on accepted `start`.
- `busy` out 1: copy in progress.
- `done` out 1: one-cycle pulse when the last write is acknowledged.
- `lines_done` out LEN_W: write acks received in the current or last copy.
- `rd_req_valid` out 1, `rd_req_addr` out ADDR_W: read request.
- `rd_almfull` in 1: read channel almost full.
- `rd_rsp_valid` in 1, `rd_rsp_data` in DATA_W: read response. Responses arrive in request order because MPF response sorting is enabled.
- `wr_req_valid` out 1, `wr_req_addr` out ADDR_W, `wr_req_data` out DATA_W: write request.
- `wr_almfull` in 1: write channel almost full.
- `wr_ack` in 1: one write completion.

## Operation
- States: IDLE, RUN, WAIT_ACK.
- IDLE:
  - `start` with `num_lines`≠0 latches the inputs, clears all counters and enters RUN.
  - `start` with `num_lines`=0 pulses `done` the next cycle and stays in IDLE.
- `start` while not IDLE is ignored.
- Read issue, per cycle in RUN: one request when `rd_issued`<`num_lines`, `credits`>0 and `!rd_almfull`.
  - `credits` = DEPTH − (reads outstanding + FIFO occupancy).
  - Address = `src_addr` + `rd_issued`, modulo 2^ADDR_W.
- Read response: pushed into the FIFO unconditionally. The credit scheme guarantees no overflow; an overflow is an assertion failure in simulation.
- Write issue, per cycle in RUN: one request when the FIFO is non-empty and `!wr_almfull`. Pops the FIFO head. Address = `dst_addr` + `wr_issued`, modulo 2^ADDR_W.
- RUN → WAIT_ACK when `wr_issued` reaches `num_lines`.
- WAIT_ACK → IDLE when `lines_done` reaches `num_lines`; `done` pulses in that same transition cycle.
- `wr_ack` increments `lines_done`. An ack and a write issue in the same cycle are both counted.
- `rd_rsp_valid` and `wr_ack` in IDLE are dropped and do not change any counter.
- `lines_done` holds its final value in IDLE until the next accepted `start`.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `lines_done`=0, `rd_req_valid`=0, `wr_req_valid`=0, addresses 0, `wr_req_data` 0.
- Reset mid-copy returns to IDLE within one cycle and empties the FIFO. Late responses and acks are then dropped per the IDLE rule.
- `start` at cycle t: `busy`=1 at t+1; first `rd_req_valid` no earlier than t+2.
- Issue decision at cycle t produces valid at t+1. The almfull inputs absorb this one-cycle slack; the block never issues more than one request per channel per cycle.
- Read response at cycle t: the data can appear on `wr_req_data` at t+2 at the earliest (FIFO write t, head visible t+1, registered output t+2).
- Credits are returned on FIFO pop, not on write ack.
- `busy` falls in the same cycle `done` is high.
- Simultaneous FIFO push and pop at full occupancy is legal; occupancy is unchanged.
- Full-rate throughput: with no backpressure and response latency L, steady state is one line per cycle when DEPTH > L+3.

## Test plan
- Basic copy:
  - Stimulus: `num_lines`=4, src 0x100, dst 0x200, response latency 5, acks 3 cycles after each write.
  - Required: reads to 0x100–0x103, writes to 0x200–0x203 carrying matching data in order, one `done` pulse, `lines_done`=4.
- Zero length:
  - Stimulus: `start` with `num_lines`=0.
  - Required: `done` pulse at t+1, no requests issued, `busy` stays 0.
- Credit limit:
  - Stimulus: DEPTH=16, `num_lines`=64, `wr_almfull` held high.
  - Required: exactly 16 reads issued and no more; after `wr_almfull` releases, the copy completes with 64 writes.
- Backpressure and wrap:
  - Stimulus: `rd_almfull` toggled every 3 cycles, dst = 2^ADDR_W−2, `num_lines`=4.
  - Required: write addresses 2^ADDR_W−2, 2^ADDR_W−1, 0, 1.
- Ignored start and simultaneous events:
  - Stimulus: second `start` mid-copy; `wr_ack` coinciding with a write issue.
  - Required: the second start has no effect, and the final `lines_done` is exact.
- Reset mid-copy:
  - Stimulus: `reset` after 10 of 32 lines, then responses keep arriving.
  - Required: all outputs at reset values, late responses ignored, and a new 8-line copy completes correctly.

Source files
------------

// File: rtl/line_copy_engine.sv
// line_copy_engine: copies num_lines host-memory lines from src to dst.
// Reads are buffered in a credit-managed FIFO and written back in order.
module line_copy_engine #(
    parameter int ADDR_W = 42,
    parameter int DATA_W = 512,
    parameter int LEN_W  = 32,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  num_lines,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  lines_done,
    output logic              rd_req_valid,
    output logic [ADDR_W-1:0] rd_req_addr,
    input  logic              rd_almfull,
    input  logic              rd_rsp_valid,
    input  logic [DATA_W-1:0] rd_rsp_data,
    output logic              wr_req_valid,
    output logic [ADDR_W-1:0] wr_req_addr,
    output logic [DATA_W-1:0] wr_req_data,
    input  logic              wr_almfull,
    input  logic              wr_ack
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_U = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_ACK
    } state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  len_q, rd_issued, wr_issued;
    logic [CNT_W-1:0]  rd_outst, fifo_cnt;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [DATA_W-1:0] mem [DEPTH];

    logic             accept, zero_start, rd_go, wr_go, push, fin;
    logic [LEN_W-1:0] ld_next;
    logic [CNT_W:0]   in_use;

    // Next state and per-cycle issue decisions; credits = DEPTH - in_use.
    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        zero_start = 1'b0;
        rd_go      = 1'b0;
        wr_go      = 1'b0;
        fin        = 1'b0;
        push       = rd_rsp_valid && (state != IDLE);
        in_use     = {1'b0, rd_outst} + {1'b0, fifo_cnt};
        ld_next    = lines_done + LEN_W'(wr_ack && (state != IDLE));
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (num_lines != '0) begin
                        accept  = 1'b1;
                        state_d = RUN;
                    end else begin
                        zero_start = 1'b1;
                    end
                end
            end
            RUN: begin
                rd_go = (rd_issued < len_q) && (in_use < DEPTH_U)
                        && !rd_almfull;
                wr_go = (fifo_cnt != '0) && (wr_issued < len_q)
                        && !wr_almfull;
                if (wr_go && (wr_issued + LEN_W'(1) == len_q))
                    state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ld_next >= len_q) begin
                    fin     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_d;
    end

    // Registered outputs and latched copy parameters.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy         <= 1'b0;
            done         <= 1'b0;
            rd_req_valid <= 1'b0;
            wr_req_valid <= 1'b0;
            rd_req_addr  <= '0;
            wr_req_addr  <= '0;
            wr_req_data  <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
        end else begin
            busy         <= (state_d != IDLE);
            done         <= zero_start || fin;
            rd_req_valid <= rd_go;
            wr_req_valid <= wr_go;
            if (accept) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                len_q <= num_lines;
            end
            if (rd_go)
                rd_req_addr <= src_q + ADDR_W'(rd_issued);
            if (wr_go) begin
                wr_req_addr <= dst_q + ADDR_W'(wr_issued);
                wr_req_data <= mem[rd_ptr];
            end
        end
    end

    // Copy progress counters, in-flight reads and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || accept) begin
            rd_issued  <= '0;
            wr_issued  <= '0;
            lines_done <= '0;
            rd_outst   <= '0;
            fifo_cnt   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
        end else begin
            lines_done <= ld_next;
            if (rd_go) rd_issued <= rd_issued + LEN_W'(1);
            if (wr_go) wr_issued <= wr_issued + LEN_W'(1);
            if (push)  wr_ptr    <= wr_ptr + PTR_W'(1);
            if (wr_go) rd_ptr    <= rd_ptr + PTR_W'(1);
            case ({rd_go, push})
                2'b10:   rd_outst <= rd_outst + CNT_W'(1);
                2'b01:   rd_outst <= rd_outst - CNT_W'(1);
                default: rd_outst <= rd_outst;
            endcase
            case ({push, wr_go})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents need no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rd_rsp_data;
    end

    // A push into a full FIFO without a pop means the credit scheme broke.
    assert property (@(posedge clk) disable iff (reset)
        !(push && !wr_go && (fifo_cnt == FULL_C)));

endmodule
